// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them while holding the core. Optional checksum stage: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_count;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_asm;
  logic                r_byte_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_busy;
  logic                r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
  logic                r_err;
`endif

  logic [CW-1:0]       w_count_clamp;
  logic                w_accept;
  logic                w_last;
  logic [31:0]         w_word;

  assign w_count_clamp = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign w_accept      = byte_valid & r_byte_ready;
  assign w_last        = (CW'(r_idx) == (r_count - CW'(1)));
  assign w_word        = {byte_data, r_asm};

  // Session FSM; mem_* outputs are non-zero only during the single WRITE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_idx        <= '0;
      r_bcnt       <= '0;
      r_asm        <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_done      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= w_count_clamp;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_busy  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= '0;
            r_err   <= 1'b0;
`endif
            if (w_count_clamp == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_RECV;
              r_byte_ready <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ byte_data;
`endif
            if (r_bcnt == 2'd3) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_idx;
              r_mem_wdata  <= w_word;
              r_bcnt       <= '0;
              r_asm        <= '0;
            end else begin
              r_asm[{r_bcnt, 3'b000} +: 8] <= byte_data;
              r_bcnt                       <= r_bcnt + 2'd1;
            end
          end
        end
        S_WRITE: begin
          if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state      <= S_CHECK;
            r_byte_ready <= 1'b1;
`else
            r_state      <= S_DONE;
            r_done       <= 1'b1;
`endif
          end else begin
            r_idx        <= r_idx + ADDR_W'(1);
            r_state      <= S_RECV;
            r_byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            r_err        <= (byte_data != r_csum);
            r_byte_ready <= 1'b0;
            r_state      <= S_DONE;
            r_done       <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_byte_ready <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_hold   = r_busy;
  assign busy       = r_busy;
  assign done       = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err        = r_err;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width (256 words).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a load session.
REQ-005 SHALL have port word_count  input  ADDR_W+1  number of 32-bit words to load.
REQ-006 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-007 SHALL have port byte_data  input  8  incoming program byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  word address for the write.
REQ-011 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-012 SHALL have port cpu_hold  output  1  holds the core (fetch PC) in reset while loading.
REQ-013 SHALL have port busy  output  1  session in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of session.
REQ-015 SHALL have port err  output  1  checksum mismatch flag.

Function
REQ-016 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE.
REQ-017 SHALL, in IDLE with start=1, latch word_count (clamped to 2^ADDR_W), clear word index and byte counter, and enter RECV next cycle; if latched count is 0, enter DONE instead.
REQ-018 SHALL ignore start in any state other than IDLE.
REQ-019 SHALL drive byte_ready=1 only in RECV and CHECK; a byte is accepted on a cycle with byte_valid=1 and byte_ready=1.
REQ-020 SHALL assemble bytes little-endian: 1st accepted byte into mem_wdata[7:0], 4th into [31:24].
REQ-021 SHALL, on the cycle the 4th byte is accepted, enter WRITE next cycle; in WRITE mem_we=1 for exactly one cycle with mem_addr=word index and mem_wdata=assembled word.
REQ-022 SHALL, after WRITE, increment the word index and return to RECV, or leave for CHECK/DONE if the index equals latched count-1.
REQ-023 SHALL tolerate arbitrary byte_valid gaps with no change of state or byte count.
REQ-024 SHALL drive done=1 for the single DONE cycle, then return to IDLE.
REQ-025 SHALL drive busy=1 and cpu_hold=1 in every state except IDLE.
REQ-026 SHALL keep mem_we=0 in all states except WRITE.

Reset
REQ-027 SHALL, on a clock edge with reset=0, enter IDLE and clear word index, byte counter, assembled word, checksum and err.
REQ-028 SHALL drive all outputs to 0 while in reset and in IDLE (err excepted in IDLE, per REQ-031).
REQ-029 SHALL discard a partially received word when reset is asserted mid-session; no mem_we is issued for it.

Configuration
REQ-030 SHALL compile a checksum stage in when macro IMEM_LOADER_CHECKSUM_EN is defined: running XOR of all accepted data bytes; after the last WRITE the FSM enters CHECK, accepts one byte and sets err=1 if it differs from the XOR, then enters DONE.
REQ-031 SHALL, with the macro defined, hold err until the next accepted start, which clears it.
REQ-032 SHALL, without the macro, omit CHECK (last WRITE goes directly to DONE) and tie err to 0.

Verification
REQ-033 SHALL cover: word_count=1, bytes 0x13,0x00,0x50,0x00 back-to-back -> one mem_we, mem_addr=0, mem_wdata=0x00500013, done pulse, cpu_hold falls after DONE.
REQ-034 SHALL cover: word_count=3, 12 bytes with random byte_valid gaps -> exactly three mem_we at addresses 0,1,2 in order, correct words.
REQ-035 SHALL cover: word_count=0 -> done pulse on cycle 2 after start, no mem_we, byte_ready never 1.
REQ-036 SHALL cover: reset=0 after 2 bytes of word 0, then new start with word_count=1 -> addr 0 written with only the new 4 bytes.
REQ-037 SHALL cover (IMEM_LOADER_CHECKSUM_EN): word 0x00500013 then checksum byte 0x43 -> err=0; repeat with 0x44 -> err=1 held until next start.
REQ-038 SHALL cover: start pulsed during RECV -> ignored, word index and latched count unchanged.
